// File: rtl/pipe_stage_pkg.sv
// Shared pipeline package: default widths, entry layout, occupancy helper.
package pipe_stage_pkg;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_CNT_W  = 16;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_CTRL_W-1:0] ctrl;
        logic [PIPE_DATA_W-1:0] data;
    } pipe_entry_t;

    function automatic logic [1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid/ctrl/data register with load and ctrl-clearing kill.
module pipe_entry
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Kill clears valid and control only; the datapath payload is left as-is.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            ctrl_q  <= valid_i ? ctrl_i : '0;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline register stage with skid entry, flush, and stall-cycle counter.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_v;
    logic [CTRL_W-1:0] main_c;
    logic [DATA_W-1:0] main_dat;
    logic              skid_v;
    logic [CTRL_W-1:0] skid_c;
    logic [DATA_W-1:0] skid_dat;

    logic              accept;
    logic              drain;
    logic              main_load;
    logic              skid_load;
    logic              main_v_d;
    logic [CTRL_W-1:0] main_c_d;
    logic [DATA_W-1:0] main_dat_d;
    logic              skid_v_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    assign in_ready  = ~skid_v;
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = main_v & out_ready;
    assign main_load = ~main_v | drain;
    assign skid_load = main_load | accept;

    // Skid has priority into main so that order is preserved.
    always_comb begin
        main_v_d   = skid_v | accept;
        main_c_d   = skid_v ? skid_c : in_ctrl;
        main_dat_d = skid_v ? skid_dat : in_data;
        skid_v_d   = accept & (skid_v | ~main_load);
    end

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (main_load),
        .clr_i   (flush),
        .valid_i (main_v_d),
        .ctrl_i  (main_c_d),
        .data_i  (main_dat_d),
        .valid_o (main_v),
        .ctrl_o  (main_c),
        .data_o  (main_dat)
    );

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (skid_load),
        .clr_i   (flush),
        .valid_i (skid_v_d),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_v),
        .ctrl_o  (skid_c),
        .data_o  (skid_dat)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (main_v && !out_ready && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = main_v;
    assign out_ctrl  = main_c & {CTRL_W{main_v}};
    assign out_data  = main_dat;
    assign occupancy = occ_count(main_v, skid_v);
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage against a FIFO-of-held-entries model.
module tb_pipe_stage;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          flush = 1'b0;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    pipe_stage #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    stall_m = 0;
    logic  rdy_m = 1'b1;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model is updated late in the cycle,
    // after the monitor has retired any drained entry.
    task automatic beat(input logic iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic ordy,
                        input logic fl);
        @(posedge clk);
        #1;
        rdy_m     = (q.size() < 2);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #6;
        if (fl) begin
            q.delete();
        end else if (iv && rdy_m) begin
            q.push_back('{c: c, d: d});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        flush    = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_ctrl", DW'(out_ctrl), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        chk("rst_occupancy", DW'(occupancy), '0);
        chk("rst_stall_cnt", DW'(stall_cnt), '0);
        q.delete();
        stall_m = 0;
        #3;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            automatic bit busy = (q.size() != 0);
            chk("out_valid", DW'(out_valid), DW'(busy));
            chk("occupancy", DW'(occupancy), DW'(q.size()));
            chk("in_ready", DW'(in_ready), DW'(q.size() < 2));
            chk("stall_cnt", DW'(stall_cnt), DW'(stall_m));
            if (busy) begin
                chk("out_data", out_data, q[0].d);
                chk("out_ctrl", DW'(out_ctrl), DW'(q[0].c));
                if (out_ready) begin
                    void'(q.pop_front());
                end
            end else begin
                chk("bubble_ctrl", DW'(out_ctrl), '0);
            end
            if (busy && !out_ready && stall_m < SAT) begin
                stall_m++;
            end
        end
    end

    initial begin
        #2;
        chk("init_out_valid", DW'(out_valid), '0);
        chk("init_out_ctrl", DW'(out_ctrl), '0);
        chk("init_out_data", out_data, '0);
        chk("init_in_ready", DW'(in_ready), DW'(1));
        chk("init_occupancy", DW'(occupancy), '0);
        chk("init_stall_cnt", DW'(stall_cnt), '0);
        #5;
        reset = 1'b0;

        beat(1'b1, DW'('hA5A5), CW'('h07), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, DW'(100 + i), CW'(i + 1), 1'b1, 1'b0);
        end
        beat(1'b0, '0, '0, 1'b1, 1'b0);
        beat(1'b0, '0, '0, 1'b1, 1'b0);

        beat(1'b1, DW'('h11), CW'(1), 1'b0, 1'b0);
        beat(1'b1, DW'('h22), CW'(2), 1'b0, 1'b0);
        beat(1'b1, DW'('h33), CW'(3), 1'b0, 1'b0);
        beat(1'b1, DW'('h33), CW'(3), 1'b0, 1'b0);
        beat(1'b1, DW'('h33), CW'(3), 1'b1, 1'b0);
        beat(1'b1, DW'('h33), CW'(3), 1'b1, 1'b0);
        beat(1'b0, '0, '0, 1'b1, 1'b0);
        beat(1'b0, '0, '0, 1'b1, 1'b0);

        do_reset();
        beat(1'b1, DW'('h55), CW'(5), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            beat(1'b0, '0, '0, 1'b0, 1'b0);
        end
        #1;
        chk("stall_saturated", DW'(stall_cnt), DW'(SAT));
        do_reset();

        beat(1'b1, DW'('h11), CW'(1), 1'b0, 1'b0);
        beat(1'b1, DW'('h22), CW'(2), 1'b0, 1'b0);
        beat(1'b1, DW'('h44), CW'(4), 1'b0, 1'b1);
        beat(1'b0, '0, '0, 1'b1, 1'b0);
        beat(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            automatic logic iv = ($urandom_range(0, 99) < 70);
            automatic logic ordy = ($urandom_range(0, 99) < 60);
            automatic logic fl = ($urandom_range(0, 99) < 5);
            automatic logic [DW-1:0] d = {$urandom, $urandom};
            automatic logic [CW-1:0] c = CW'($urandom);
            if (i == 1500) begin
                do_reset();
            end
            beat(iv, d, c, ordy, fl);
        end
        beat(1'b0, '0, '0, 1'b1, 1'b0);
        beat(1'b0, '0, '0, 1'b1, 1'b0);
        beat(1'b0, '0, '0, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
